// File: rtl/ps2_pkg.sv
// Shared scancode constants, prefix FSM states and direction encoding for the
// PS/2 two-player direction decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic valid;
    logic player;
    dir_t dir;
  } code_map_t;

  // Non-extended codes belong to player 0, extended codes to player 1; any
  // other combination (wrong extended-ness included) is not a direction.
  function automatic code_map_t map_code(input logic [7:0] code, input logic ext);
    code_map_t m;
    m.valid  = 1'b1;
    m.player = ext;
    m.dir    = DIR_UP;
    if (!ext) begin
      case (code)
        SC_W:    m.dir = DIR_UP;
        SC_D:    m.dir = DIR_RIGHT;
        SC_S:    m.dir = DIR_DOWN;
        SC_A:    m.dir = DIR_LEFT;
        default: m.valid = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    m.dir = DIR_UP;
        SC_RIGHT: m.dir = DIR_RIGHT;
        SC_DOWN:  m.dir = DIR_DOWN;
        SC_LEFT:  m.dir = DIR_LEFT;
        default:  m.valid = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_if.sv
// Received-byte bus from the PS/2 receiver: one-cycle strobe plus scancode byte.
interface ps2_if;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;

  modport master (output ps2_key_pressed, output ps2_out);
  modport slave  (input  ps2_key_pressed, input  ps2_out);
endinterface

// File: rtl/ps2_dir_decoder_arbiter.sv
// Per-player held/last key tracking with registered one-hot direction output.
// The output register is fed from next-state so a make/break shows one cycle later.
import ps2_pkg::*;

module dir_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       make,
  input  logic       brk,
  input  dir_t       dir,
  output logic [3:0] dir_out
);

  logic [3:0] held_q, held_d;
  dir_t       last_q, last_d;
  logic [3:0] out_q, out_d;

  always_comb begin
    held_d = held_q;
    last_d = last_q;
    out_d  = 4'b0000;
    if (clear) begin
      held_d = 4'b0000;
      last_d = DIR_UP;
    end else if (make) begin
      held_d[dir] = 1'b1;
      last_d      = dir;
    end else if (brk) begin
      held_d[dir] = 1'b0;
    end

    // Most recent make wins while it is still held; otherwise fall back by priority.
    if (held_d[last_d])    out_d[last_d] = 1'b1;
    else if (held_d[0])    out_d[0] = 1'b1;
    else if (held_d[1])    out_d[1] = 1'b1;
    else if (held_d[2])    out_d[2] = 1'b1;
    else if (held_d[3])    out_d[3] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_q <= 4'b0000;
      last_q <= DIR_UP;
      out_q  <= 4'b0000;
    end else begin
      held_q <= held_d;
      last_q <= last_d;
      out_q  <= out_d;
    end
  end

  assign dir_out = out_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// Two-player direction decoder for PS/2 scan set 2: prefix FSM, idle timeout
// and one dir_arbiter per player.
import ps2_pkg::*;

module ps2_dir_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  ps2_if.slave ps2,
  output logic upSig,
  output logic rightSig,
  output logic downSig,
  output logic leftSig,
  output logic upSig2,
  output logic rightSig2,
  output logic downSig2,
  output logic leftSig2
);

  localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LIMIT      = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  prefix_state_t state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          fire, make, brk, ext_code;
  code_map_t     hit;
  logic [3:0]    p0_out, p1_out;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fire     = 1'b0;
    make     = 1'b0;
    brk      = 1'b0;
    ext_code = 1'b0;
    if (ps2.ps2_key_pressed) begin
      cnt_d = 32'd0;
      case (state_q)
        ST_IDLE: begin
          if (ps2.ps2_out == SC_EXT)      state_d = ST_EXT;
          else if (ps2.ps2_out == SC_BRK) state_d = ST_BRK;
          else                            make = 1'b1;
        end
        ST_EXT: begin
          if (ps2.ps2_out == SC_BRK)      state_d = ST_EXT_BRK;
          else if (ps2.ps2_out != SC_EXT) begin
            make     = 1'b1;
            ext_code = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk     = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk      = 1'b1;
          ext_code = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (TIMEOUT_EN) begin
      // Saturate at the limit; the clear keeps re-asserting harmlessly until the next byte.
      if (cnt_q != LIMIT) cnt_d = cnt_q + 32'd1;
      if (cnt_d == LIMIT) begin
        fire    = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hit = map_code(ps2.ps2_out, ext_code);

  dir_arbiter u_player0 (
    .clock   (clock),
    .reset   (reset),
    .clear   (fire),
    .make    (make & hit.valid & ~hit.player),
    .brk     (brk & hit.valid & ~hit.player),
    .dir     (hit.dir),
    .dir_out (p0_out)
  );

  dir_arbiter u_player1 (
    .clock   (clock),
    .reset   (reset),
    .clear   (fire),
    .make    (make & hit.valid & hit.player),
    .brk     (brk & hit.valid & hit.player),
    .dir     (hit.dir),
    .dir_out (p1_out)
  );

  assign upSig     = p0_out[0];
  assign rightSig  = p0_out[1];
  assign downSig   = p0_out[2];
  assign leftSig   = p0_out[3];
  assign upSig2    = p1_out[0];
  assign rightSig2 = p1_out[1];
  assign downSig2  = p1_out[2];
  assign leftSig2  = p1_out[3];

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder: directed scenarios plus random byte
// streams, checked against a behavioural key-state model.
module tb_ps2_dir_decoder;

  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset;
  logic upSig, rightSig, downSig, leftSig;
  logic upSig2, rightSig2, downSig2, leftSig2;
  logic [7:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  // Behavioural model state: pending prefixes, held keys, last make, idle cycles.
  bit       m_ext, m_brk;
  bit [3:0] m_held [2];
  int       m_last [2];
  int       m_idle;

  byte unsigned p0_codes [4] = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
  byte unsigned p1_codes [4] = '{8'h75, 8'h74, 8'h72, 8'h6B};
  byte unsigned pool [10]    = '{8'hE0, 8'hF0, 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h75, 8'h74, 8'h72, 8'h6B};

  ps2_if bus ();

  always #5 clock = ~clock;

  ps2_dir_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2       (bus),
    .upSig     (upSig),
    .rightSig  (rightSig),
    .downSig   (downSig),
    .leftSig   (leftSig),
    .upSig2    (upSig2),
    .rightSig2 (rightSig2),
    .downSig2  (downSig2),
    .leftSig2  (leftSig2)
  );

  assign dut_vec = {upSig, rightSig, downSig, leftSig, upSig2, rightSig2, downSig2, leftSig2};

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  function automatic int m_lookup(input byte unsigned code, input bit ext, output int player);
    player = ext ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (!ext && code == p0_codes[i]) return i;
      if (ext && code == p1_codes[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit [3:0] m_view(input int p);
    if (m_held[p][m_last[p]]) return 4'(1 << m_last[p]);
    for (int d = 0; d < 4; d++)
      if (m_held[p][d]) return 4'(1 << d);
    return 4'b0000;
  endfunction

  function automatic logic [7:0] m_pack();
    bit [3:0] v0, v1;
    v0 = m_view(0);
    v1 = m_view(1);
    return {v0[0], v0[1], v0[2], v0[3], v1[0], v1[1], v1[2], v1[3]};
  endfunction

  function automatic void m_clear();
    m_ext = 0; m_brk = 0;
    for (int p = 0; p < 2; p++) begin
      m_held[p] = 4'b0000;
      m_last[p] = 0;
    end
  endfunction

  function automatic void model_step(input bit rst, input bit stb, input byte unsigned data);
    int d, p;
    if (rst) begin
      m_clear();
      m_idle = 0;
    end else if (stb) begin
      m_idle = 0;
      if (!m_brk && data == 8'hE0) m_ext = 1;
      else if (!m_brk && data == 8'hF0) m_brk = 1;
      else begin
        d = m_lookup(data, m_ext, p);
        if (d >= 0) begin
          if (m_brk) m_held[p][d] = 1'b0;
          else begin
            m_held[p][d] = 1'b1;
            m_last[p]    = d;
          end
        end
        m_ext = 0;
        m_brk = 0;
      end
    end else begin
      if (m_idle != TO - 1) m_idle++;
      if (m_idle == TO - 1) m_clear();
    end
  endfunction

  // One call per clock: drive on the falling edge, predict the post-edge outputs.
  task automatic applyStimulus(input bit rst, input bit stb, input byte unsigned data);
    @(negedge clock);
    reset               = rst;
    bus.ps2_key_pressed = stb;
    bus.ps2_out         = data;
    model_step(rst, stb, data);
    exp_q.push_back(m_pack());
  endtask

  task automatic sendByte(input byte unsigned data);
    applyStimulus(0, 1, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00);
  endtask

  task automatic pulseReset();
    applyStimulus(1, 0, 8'h00);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] want);
    @(posedge clock);
    #1;
    check(name, dut_vec, want);
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) check("scoreboard", dut_vec, exp_q.pop_front());
  end

  initial begin
    m_clear();
    m_idle = 0;

    applyStimulus(1, 1, 8'h1D);
    pulseReset();
    checkOutput("reset_state", 8'b0000_0000);

    sendByte(8'h1D); sendByte(8'h23);
    checkOutput("w_then_d_right", 8'b0100_0000);
    sendByte(8'hF0); sendByte(8'h23);
    checkOutput("release_d_up", 8'b1000_0000);
    sendByte(8'h23); sendByte(8'h1D);
    checkOutput("typematic_up", 8'b1000_0000);

    pulseReset();
    sendByte(8'hE0); sendByte(8'h6B);
    checkOutput("p1_left", 8'b0000_0001);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
    checkOutput("p1_release", 8'b0000_0000);

    pulseReset();
    sendByte(8'h1B); sendByte(8'h1C);
    checkOutput("s_a_left", 8'b0001_0000);
    sendByte(8'hF0); sendByte(8'h1C);
    checkOutput("fallback_down", 8'b0010_0000);
    sendByte(8'h1D);
    checkOutput("then_up", 8'b1000_0000);

    pulseReset();
    sendByte(8'hE0); sendByte(8'hF0);
    pulseReset();
    sendByte(8'h75);
    checkOutput("reset_discards_prefix", 8'b0000_0000);
    sendByte(8'hE0); sendByte(8'h75);
    checkOutput("p1_up", 8'b0000_1000);

    pulseReset();
    sendByte(8'h75);
    checkOutput("bare_75_ignored", 8'b0000_0000);
    sendByte(8'hE0); sendByte(8'h1D);
    checkOutput("e0_1d_ignored", 8'b0000_0000);
    sendByte(8'h1D);
    checkOutput("fsm_back_idle", 8'b1000_0000);

    pulseReset();
    sendByte(8'h1D);
    idle(13);
    applyStimulus(0, 0, 8'h00);
    checkOutput("timeout_cnt14_held", 8'b1000_0000);
    applyStimulus(0, 0, 8'h00);
    checkOutput("timeout_cnt15_clear", 8'b0000_0000);
    idle(5);
    sendByte(8'h23);
    checkOutput("after_saturate", 8'b0100_0000);

    pulseReset();
    sendByte(8'h1D);
    idle(14);
    sendByte(8'h23);
    checkOutput("strobe_beats_timeout", 8'b0100_0000);
    idle(14);
    checkOutput("recount_held", 8'b0100_0000);
    applyStimulus(0, 0, 8'h00);
    checkOutput("recount_clear", 8'b0000_0000);

    pulseReset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) pulseReset();
      else if (r < 50) begin
        int k;
        k = $urandom_range(0, 11);
        if (k < 10) sendByte(pool[k]);
        else sendByte(8'($urandom));
      end else if (r == 99) idle(TO + 4);
      else idle(1);
    end

    @(posedge clock);
    #2;
    if (exp_q.size() != 0) check("scoreboard_drain", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
